// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and default widths for the APB master bridge.
//  Revision    : 1.0
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : apb_timeout_cnt
//  Description : Saturating ACCESS-phase wait counter; flags the final cycle.
//  Revision    : 1.0
// ============================================================================
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("apb_timeout_cnt: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [CNT_W-1:0] r_count;

    // Holds at the last count so it can never wrap back to zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Single-outstanding command stream to APB master with timeout.
//  Revision    : 1.0
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_mst_state_e        r_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic w_cnt_clear;
    logic w_cnt_enable;
    logic w_expired;

    assign w_cnt_clear  = (r_state == SETUP);
    assign w_cnt_enable = (r_state == ACCESS) && !pready;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk     (pclk),
        .presetn  (presetn),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .o_expired(w_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= IDLE;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_paddr   <= cmd_addr;
                        r_pwrite  <= cmd_write;
                        r_pwdata  <= cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // A completion on the final count cycle takes priority over the abort.
                    if (pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign paddr       = r_paddr;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Bench for apb_master_bridge with a stallable APB RAM slave.
//  Revision    : 1.0
// ============================================================================
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int T  = 16;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr  = '0;
    logic          cmd_write = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata  = '0;
    logic          pready  = 1'b0;
    logic          pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // APB RAM slave: pready on access cycle cfg_wait (0-based); noise elsewhere.
    logic [DW-1:0] slv_mem [1024];
    int            cfg_wait = 0;
    logic          cfg_err  = 1'b0;
    int            acc_k    = 0;

    always @(negedge pclk) begin
        if (!presetn) begin
            acc_k   = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = $urandom;
        end else if (psel && penable) begin
            if (acc_k == cfg_wait) begin
                pready  = 1'b1;
                pslverr = cfg_err;
                prdata  = pwrite ? $urandom : slv_mem[paddr];
                if (pwrite && !cfg_err) slv_mem[paddr] = pwdata;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            acc_k++;
        end else begin
            acc_k   = 0;
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    // Transaction-level model: each command is a timeline of edge numbers.
    logic [DW-1:0] mdl_mem [1024];
    int            e = 0;
    bit            m_busy = 1'b0;
    int            m_t0 = 0;
    int            m_tr = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_wr = 1'b0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_rd = '0;
    logic          m_err = 1'b0;
    logic          m_to = 1'b0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_busy = 1'b0;
        end else begin
            e++;
            if (m_busy) begin
                if (e > m_tr && rsp_ready) m_busy = 1'b0;
            end else if (cmd_valid) begin
                m_busy = 1'b1;
                m_t0   = e;
                m_addr = cmd_addr;
                m_wr   = cmd_write;
                m_wd   = cmd_wdata;
                if (cfg_wait < T) begin
                    m_tr  = e + 2 + cfg_wait;
                    m_to  = 1'b0;
                    m_err = cfg_err;
                    m_rd  = cmd_write ? '0 : mdl_mem[cmd_addr];
                    if (cmd_write && !cfg_err) mdl_mem[cmd_addr] = cmd_wdata;
                end else begin
                    m_tr  = e + 1 + T;
                    m_to  = 1'b1;
                    m_err = 1'b1;
                    m_rd  = '0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge pclk) begin
        if (!presetn) begin
            chk("rst_psel", psel, 0);
            chk("rst_penable", penable, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_pwrite", pwrite, 0);
            chk("rst_paddr", paddr, 0);
            chk("rst_pwdata", pwdata, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
        end else begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("psel", psel, m_busy && e < m_tr);
            chk("penable", penable, m_busy && e > m_t0 && e < m_tr);
            chk("rsp_valid", rsp_valid, m_busy && e >= m_tr);
            if (m_busy && e < m_tr) begin
                chk("paddr", paddr, m_addr);
                chk("pwrite", pwrite, m_wr);
                chk("pwdata", pwdata, m_wd);
            end
            if (m_busy && e >= m_tr) begin
                chk("rsp_rdata", rsp_rdata, m_rd);
                chk("rsp_err", rsp_err, m_err);
                chk("rsp_timeout", rsp_timeout, m_to);
            end
        end
    end

    // Edge stamps of observed DUT events for literal latency checks.
    int cyc = 0, acc_c = 0, rv_c = 0, pen_c = 0;
    logic prv = 1'b0, ppen = 1'b0;
    always @(posedge pclk) begin
        cyc++;
        if (cmd_valid && cmd_ready) acc_c = cyc;
        if (rsp_valid && !prv) rv_c = cyc;
        if (penable && !ppen) pen_c = cyc;
        prv  = rsp_valid;
        ppen = penable;
    end

    logic [DW-1:0] last_rdata;
    logic          last_err, last_to;

    task automatic run_cmd(input apb_cmd_t c, input int w, input logic er, input int hold);
        int n;
        @(negedge pclk);
        cfg_wait  = w;
        cfg_err   = er;
        cmd_valid = 1'b1;
        cmd_addr  = c.addr;
        cmd_write = c.write;
        cmd_wdata = c.wdata;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge pclk); n++; end
        if (n >= 100) chk("accept_timeout", 1, 0);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 400) begin @(negedge pclk); n++; end
        if (n >= 400) chk("response_timeout", 1, 0);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        last_to    = rsp_timeout;
        repeat (hold) @(negedge pclk);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        @(negedge pclk);
    endtask

    function automatic apb_cmd_t mk(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
        apb_cmd_t c;
        c.addr  = a;
        c.write = wr;
        c.wdata = d;
        return c;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = 32'hC0DE_0000 | i;
            mdl_mem[i] = 32'hC0DE_0000 | i;
        end
        presetn = 1'b1;
        #1 presetn = 1'b0;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        // Write then read back through the RAM, minimum latency both ways.
        run_cmd(mk(10'h3A5, 1'b1, 32'hDEADBEEF), 0, 1'b0, 0);
        chk("t1_wr_latency", rv_c - acc_c, 3);
        run_cmd(mk(10'h3A5, 1'b0, 32'h0), 0, 1'b0, 0);
        chk("t1_rd_latency", rv_c - acc_c, 3);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        chk("t1_err", last_err, 0);

        // Write response carries no data.
        run_cmd(mk(10'h000, 1'b1, 32'h1), 0, 1'b0, 0);
        chk("t2_rdata", last_rdata, 0);
        chk("t2_err_to", {last_err, last_to}, 0);

        // Dead slave.
        run_cmd(mk(10'h010, 1'b0, 32'h0), 255, 1'b0, 0);
        chk("t3_timeout_latency", rv_c - pen_c, 16);
        chk("t3_err_to", {last_err, last_to}, 2'b11);
        chk("t3_rdata", last_rdata, 0);

        // Response backpressure, then a following command must be accepted.
        run_cmd(mk(10'h3A5, 1'b0, 32'h0), 0, 1'b0, 5);
        chk("t4_rdata", last_rdata, 32'hDEADBEEF);
        run_cmd(mk(10'h3A5, 1'b1, 32'h12345678), 2, 1'b0, 0);
        chk("t4_next_err", last_err, 0);

        // Reset in the middle of a stalled ACCESS phase.
        @(negedge pclk);
        cfg_wait  = 255;
        cmd_valid = 1'b1;
        cmd_addr  = 10'h3A5;
        cmd_write = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        chk("t5_psel", psel, 0);
        chk("t5_penable", penable, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        run_cmd(mk(10'h3A5, 1'b0, 32'h0), 1, 1'b0, 0);
        chk("t5_rdata", last_rdata, 32'h12345678);
        chk("t5_err_to", {last_err, last_to}, 0);

        // pready on the final count cycle beats the abort.
        run_cmd(mk(10'h020, 1'b0, 32'h0), 15, 1'b0, 0);
        chk("t6_latency", rv_c - pen_c, 16);
        chk("t6_rdata", last_rdata, 32'hC0DE0020);
        chk("t6_err_to", {last_err, last_to}, 0);
        run_cmd(mk(10'h021, 1'b0, 32'h0), 15, 1'b1, 1);
        chk("t6_slverr", {last_err, last_to}, 2'b10);
        chk("t6_slverr_rdata", last_rdata, 32'hC0DE0021);

        // Randomized traffic checked by the per-cycle model.
        for (int k = 0; k < 60; k++) begin
            int r, w;
            r = $urandom_range(0, 9);
            if (r < 6)       w = r % 4;
            else if (r == 6) w = 14;
            else if (r == 7) w = 15;
            else if (r == 8) w = 16;
            else             w = $urandom_range(17, 40);
            run_cmd(mk(AW'(10'h100 + $urandom_range(0, 7)), 1'($urandom), $urandom), w,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        repeat (3) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
